// File: rtl/beat_timing_gen_if.sv
// rtl/beat_timing_gen_if.sv - controller-side bundle: SHORT/LONG/STOP feedback, phase pulses, beat levels, status
interface beat_timing_gen_if #(
    parameter int CNT_W = 8
);
    logic             SHORT;
    logic             LONG;
    logic             STOP;
    logic             T1;
    logic             T2;
    logic             T3;
    logic [2:0]       W;
    logic             RUN;
    logic [CNT_W-1:0] BCNT;

    // The timing generator drives phases/beats and listens to the controller.
    modport master (
        input  SHORT, LONG, STOP,
        output T1, T2, T3, W, RUN, BCNT
    );

    // The hardwired controller decodes phases/beats and feeds back control.
    modport slave (
        output SHORT, LONG, STOP,
        input  T1, T2, T3, W, RUN, BCNT
    );
endinterface

// File: rtl/beat_timing_gen.sv
// rtl/beat_timing_gen.sv - T1/T2/T3 phase and W1/W2/W3 beat generator; optional DP single-beat via BEAT_SINGLE_STEP_EN
module beat_timing_gen #(
    parameter int CNT_W = 8
) (
    input  logic                   MF,
    input  logic                   CLR,
    input  logic                   QD,
`ifdef BEAT_SINGLE_STEP_EN
    input  logic                   DP,
`endif
    beat_timing_gen_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        PH3  = 2'd3
    } phase_t;

    phase_t           state;
    logic             q1;
    logic             q2;
    logic             qd_edge;
    logic             halt_req;
    logic [2:0]       w_reg;
    logic [2:0]       w_next;
    logic             t1_reg;
    logic             t2_reg;
    logic             t3_reg;
    logic             run_reg;
    logic [CNT_W-1:0] bcnt_reg;

    // Rising edge of the synchronised start button.
    assign qd_edge = q1 & ~q2;

`ifdef BEAT_SINGLE_STEP_EN
    assign halt_req = bus.STOP | DP;
`else
    assign halt_req = bus.STOP;
`endif

    // Next beat level chosen from the controller feedback at the end of PH3.
    always_comb begin
        w_next = 3'b001;
        case (w_reg)
            3'b001:  w_next = bus.SHORT ? 3'b001 : 3'b010;
            3'b010:  w_next = bus.LONG  ? 3'b100 : 3'b001;
            3'b100:  w_next = 3'b001;
            default: w_next = 3'b001;
        endcase
    end

    // Start synchroniser, phase FSM, beat register and beat counter.
    always_ff @(posedge MF or negedge CLR) begin
        if (!CLR) begin
            q1       <= 1'b1;
            q2       <= 1'b1;
            state    <= IDLE;
            w_reg    <= 3'b001;
            t1_reg   <= 1'b0;
            t2_reg   <= 1'b0;
            t3_reg   <= 1'b0;
            run_reg  <= 1'b0;
            bcnt_reg <= '0;
        end else begin
            q1 <= QD;
            q2 <= q1;
            case (state)
                IDLE: begin
                    if (qd_edge) begin
                        state   <= PH1;
                        run_reg <= 1'b1;
                        t1_reg  <= 1'b1;
                    end
                end
                PH1: begin
                    state  <= PH2;
                    t1_reg <= 1'b0;
                    t2_reg <= 1'b1;
                end
                PH2: begin
                    state  <= PH3;
                    t2_reg <= 1'b0;
                    t3_reg <= 1'b1;
                end
                PH3: begin
                    t3_reg   <= 1'b0;
                    w_reg    <= w_next;
                    bcnt_reg <= bcnt_reg + 1'b1;
                    if (halt_req) begin
                        state   <= IDLE;
                        run_reg <= 1'b0;
                    end else begin
                        state  <= PH1;
                        t1_reg <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    run_reg <= 1'b0;
                    t1_reg  <= 1'b0;
                    t2_reg  <= 1'b0;
                    t3_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.T1   = t1_reg;
    assign bus.T2   = t2_reg;
    assign bus.T3   = t3_reg;
    assign bus.W    = w_reg;
    assign bus.RUN  = run_reg;
    assign bus.BCNT = bcnt_reg;

endmodule
